// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM state encoding, forwarding select codes and the PC register index.
package pipeline_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_t;

  localparam logic [3:0] PC_REG = 4'hF;

  // True when an ID source is really read, is not the PC, and names rd.
  function automatic logic srcHit(input logic [3:0] src, input logic used,
                                  input logic [3:0] rd);
    return used && (src != PC_REG) && (src == rd);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding selector: the youngest stage writing the source
// register wins; a load sitting in EX has no data yet and never forwards.
module fwd_select
  import pipeline_pkg::*;
(
  input  logic [3:0] i_src,
  input  logic       i_used,
  input  logic [3:0] i_exRd,
  input  logic       i_exRfE,
  input  logic       i_exLoad,
  input  logic [3:0] i_memRd,
  input  logic       i_memRfE,
  input  logic [3:0] i_wbRd,
  input  logic       i_wbRfE,
  output logic [1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_used && (i_src != PC_REG)) begin
      if (i_exRfE && !i_exLoad && (i_exRd == i_src)) begin
        o_sel = FWD_EX;
      end else if (i_memRfE && (i_memRd == i_src)) begin
        o_sel = FWD_MEM;
      end else if (i_wbRfE && (i_wbRd == i_src)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: post-reset hold,
// load-use stalls, branch flushes, data-memory waits and forwarding selects.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int RESET_HOLD = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic [3:0]       ex_rd,
  input  logic [3:0]       mem_rd,
  input  logic [3:0]       wb_rd,
  input  logic             ex_rf_e,
  input  logic             mem_rf_e,
  input  logic             wb_rf_e,
  input  logic             ex_load,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             nop_sel,
  output logic             ifid_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t            r_state;
  state_t            w_nextState;
  logic [HOLD_W-1:0] r_holdCnt;
  logic [CNT_W-1:0]  r_stallCnt;
  logic [CNT_W-1:0]  r_flushCnt;
  logic [CNT_W-1:0]  r_waitCnt;
  logic [4:0]        w_en;
  logic              w_nop;
  logic              w_flush;
  logic              w_loadUse;
  logic              w_stallInc;
  logic              w_flushInc;
  logic              w_waitInc;

  assign w_loadUse = ex_load && ex_rf_e &&
                     (srcHit(id_rn, id_use_rn, ex_rd) ||
                      srcHit(id_rm, id_use_rm, ex_rd) ||
                      srcHit(id_rd, id_use_rd, ex_rd));

  // WAIT with memory released behaves exactly like RUN in the same cycle.
  always_comb begin
    w_nextState = r_state;
    w_en        = 5'b00000;
    w_nop       = 1'b0;
    w_flush     = 1'b0;
    w_stallInc  = 1'b0;
    w_flushInc  = 1'b0;
    w_waitInc   = 1'b0;
    case (r_state)
      HOLD: begin
        w_nop   = 1'b1;
        w_flush = 1'b1;
        if (r_holdCnt == '0) begin
          w_nextState = RUN;
        end
      end
      RUN, WAIT: begin
        if (dmem_busy) begin
          w_nextState = WAIT;
          w_waitInc   = 1'b1;
        end else begin
          w_nextState = RUN;
          if (w_loadUse) begin
            w_en       = 5'b00111;
            w_nop      = 1'b1;
            w_stallInc = 1'b1;
          end else if (branch_taken) begin
            w_en       = 5'b11111;
            w_flush    = 1'b1;
            w_flushInc = 1'b1;
          end else begin
            w_en = 5'b11111;
          end
        end
      end
      default: begin
        w_nextState = HOLD;
        w_nop       = 1'b1;
        w_flush     = 1'b1;
      end
    endcase
    if (reset) begin
      w_en       = 5'b00000;
      w_nop      = 1'b1;
      w_flush    = 1'b1;
      w_stallInc = 1'b0;
      w_flushInc = 1'b0;
      w_waitInc  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= HOLD;
      r_holdCnt  <= HOLD_INIT;
      r_stallCnt <= '0;
      r_flushCnt <= '0;
      r_waitCnt  <= '0;
    end else begin
      r_state <= w_nextState;
      if ((r_state == HOLD) && (r_holdCnt != '0)) begin
        r_holdCnt <= r_holdCnt - 1'b1;
      end
      if (w_stallInc && (r_stallCnt != CNT_MAX)) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
      if (w_flushInc && (r_flushCnt != CNT_MAX)) begin
        r_flushCnt <= r_flushCnt + 1'b1;
      end
      if (w_waitInc && (r_waitCnt != CNT_MAX)) begin
        r_waitCnt <= r_waitCnt + 1'b1;
      end
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = w_en;
  assign nop_sel    = w_nop;
  assign ifid_flush = w_flush;
  assign busy       = reset || (r_state == HOLD);
  assign stall_cnt  = r_stallCnt;
  assign flush_cnt  = r_flushCnt;
  assign wait_cnt   = r_waitCnt;

  fwd_select u_fwdRn (
    .i_src(id_rn), .i_used(id_use_rn),
    .i_exRd(ex_rd), .i_exRfE(ex_rf_e), .i_exLoad(ex_load),
    .i_memRd(mem_rd), .i_memRfE(mem_rf_e),
    .i_wbRd(wb_rd), .i_wbRfE(wb_rf_e),
    .o_sel(fwd_a)
  );

  fwd_select u_fwdRm (
    .i_src(id_rm), .i_used(id_use_rm),
    .i_exRd(ex_rd), .i_exRfE(ex_rf_e), .i_exLoad(ex_load),
    .i_memRd(mem_rd), .i_memRfE(mem_rf_e),
    .i_wbRd(wb_rd), .i_wbRfE(wb_rf_e),
    .o_sel(fwd_b)
  );

  fwd_select u_fwdRd (
    .i_src(id_rd), .i_used(id_use_rd),
    .i_exRd(ex_rd), .i_exRfE(ex_rf_e), .i_exLoad(ex_load),
    .i_memRd(mem_rd), .i_memRfE(mem_rf_e),
    .i_wbRd(wb_rd), .i_wbRfE(wb_rf_e),
    .o_sel(fwd_c)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int RESET_HOLD = 4;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       id_rn, id_rm, id_rd;
  logic             id_use_rn, id_use_rm, id_use_rd;
  logic [3:0]       ex_rd, mem_rd, wb_rd;
  logic             ex_rf_e, mem_rf_e, wb_rf_e;
  logic             ex_load, branch_taken, dmem_busy;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             nop_sel, ifid_flush, busy;
  logic [1:0]       fwd_a, fwd_b, fwd_c;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: frozen-cycle budget left after reset plus event tallies.
  bit mHold;
  int mHoldLeft;
  int mStall, mFlush, mWait;

  pipeline_hazard_ctrl #(.RESET_HOLD(RESET_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_e(ex_rf_e), .mem_rf_e(mem_rf_e), .wb_rf_e(wb_rf_e),
    .ex_load(ex_load), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .nop_sel(nop_sel), .ifid_flush(ifid_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .busy(busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [1:0] expFwd(input logic [3:0] src, input logic used);
    if (!used || src == 4'hF) return 2'b00;
    if (ex_rf_e && !ex_load && ex_rd == src) return 2'b01;
    if (mem_rf_e && mem_rd == src) return 2'b10;
    if (wb_rf_e && wb_rd == src) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit readsReg(input logic [3:0] src, input logic used,
                                  input logic [3:0] dst);
    return used && src != 4'hF && src == dst;
  endfunction

  function automatic int bump(input int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Inputs are already driven; check this cycle, then advance the model across the edge.
  task automatic applyStimulus();
    bit         loadUse;
    logic [4:0] eEn;
    bit         eNop, eFlush, eBusy;
    #1;
    loadUse = ex_load && ex_rf_e &&
              (readsReg(id_rn, id_use_rn, ex_rd) || readsReg(id_rm, id_use_rm, ex_rd) ||
               readsReg(id_rd, id_use_rd, ex_rd));
    eBusy = reset || mHold;
    eNop = 1'b0; eFlush = 1'b0; eEn = 5'b11111;
    if (eBusy) begin
      eEn = 5'b00000; eNop = 1'b1; eFlush = 1'b1;
    end else if (dmem_busy) begin
      eEn = 5'b00000;
    end else if (loadUse) begin
      eEn = 5'b00111; eNop = 1'b1;
    end else if (branch_taken) begin
      eFlush = 1'b1;
    end
    checkOutput("enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, eEn);
    checkOutput("nop_sel", nop_sel, eNop);
    checkOutput("ifid_flush", ifid_flush, eFlush);
    checkOutput("busy", busy, eBusy);
    checkOutput("fwd_a", fwd_a, expFwd(id_rn, id_use_rn));
    checkOutput("fwd_b", fwd_b, expFwd(id_rm, id_use_rm));
    checkOutput("fwd_c", fwd_c, expFwd(id_rd, id_use_rd));
    checkOutput("stall_cnt", stall_cnt, mStall);
    checkOutput("flush_cnt", flush_cnt, mFlush);
    checkOutput("wait_cnt", wait_cnt, mWait);
    if (reset) begin
      mHold = 1'b1; mHoldLeft = RESET_HOLD;
      mStall = 0; mFlush = 0; mWait = 0;
    end else if (mHold) begin
      mHoldLeft--;
      if (mHoldLeft == 0) mHold = 1'b0;
    end else if (dmem_busy) begin
      mWait = bump(mWait);
    end else if (loadUse) begin
      mStall = bump(mStall);
    end else if (branch_taken) begin
      mFlush = bump(mFlush);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clearInputs();
    id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
    ex_rd = 4'd0; mem_rd = 4'd0; wb_rd = 4'd0;
    ex_rf_e = 1'b0; mem_rf_e = 1'b0; wb_rf_e = 1'b0;
    ex_load = 1'b0; branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  function automatic logic [3:0] rndReg();
    return ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b1;
    clearInputs();
    @(posedge clk);
    @(negedge clk);
    mHold = 1'b1; mHoldLeft = RESET_HOLD;
    mStall = 0; mFlush = 0; mWait = 0;

    // Reset, then the frozen window and the first running cycle.
    applyStimulus();
    reset = 1'b0;
    repeat (6) applyStimulus();

    // Load-use stall, then the load has moved to MEM.
    ex_load = 1'b1; ex_rf_e = 1'b1; ex_rd = 4'd3; id_rn = 4'd3; id_use_rn = 1'b1;
    applyStimulus();
    ex_load = 1'b0; ex_rf_e = 1'b0; ex_rd = 4'd0; mem_rd = 4'd3; mem_rf_e = 1'b1;
    applyStimulus();

    // Forwarding priority and the PC exclusion.
    clearInputs();
    ex_rd = 4'd5; mem_rd = 4'd5; wb_rd = 4'd5;
    ex_rf_e = 1'b1; mem_rf_e = 1'b1; wb_rf_e = 1'b1;
    id_rm = 4'd5; id_use_rm = 1'b1;
    applyStimulus();
    ex_rf_e = 1'b0;
    applyStimulus();
    id_rm = 4'hF;
    applyStimulus();

    // Branch alone, then branch together with a load-use on rn.
    clearInputs();
    branch_taken = 1'b1;
    applyStimulus();
    id_rn = 4'd2; id_use_rn = 1'b1; ex_rd = 4'd2; ex_load = 1'b1; ex_rf_e = 1'b1;
    applyStimulus();

    // Three-cycle memory wait.
    clearInputs();
    dmem_busy = 1'b1;
    repeat (3) applyStimulus();
    dmem_busy = 1'b0;
    applyStimulus();

    // Reset landing in the middle of a wait.
    dmem_busy = 1'b1;
    applyStimulus();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0; dmem_busy = 1'b0;
    repeat (5) applyStimulus();

    // Counter saturation under a long run of stalls.
    ex_load = 1'b1; ex_rf_e = 1'b1; ex_rd = 4'd7; id_rm = 4'd7; id_use_rm = 1'b1;
    repeat (20) applyStimulus();
    checkOutput("stallSat", stall_cnt, CNT_MAX);

    // Random traffic with occasional resets.
    repeat (3000) begin
      reset        = ($urandom_range(0, 63) == 0);
      id_rn        = rndReg(); id_rm = rndReg(); id_rd = rndReg();
      id_use_rn    = 1'($urandom); id_use_rm = 1'($urandom); id_use_rd = 1'($urandom);
      ex_rd        = rndReg(); mem_rd = rndReg(); wb_rd = rndReg();
      ex_rf_e      = 1'($urandom); mem_rf_e = 1'($urandom); wb_rf_e = 1'($urandom);
      ex_load      = 1'($urandom);
      branch_taken = ($urandom_range(0, 3) == 0);
      dmem_busy    = ($urandom_range(0, 4) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
- Drives the PC and pipeline-register enables, the NOP-insert select ("S") on the ID control mux, the IF/ID flush and the three operand-forwarding selects.
- Holds the pipeline frozen for a programmable number of cycles after reset so the instruction memory can be preloaded.
- Adds multi-cycle data-memory wait handling and saturating performance counters.

Parameters:
- RESET_HOLD, default 4: cycles the pipeline stays frozen after reset deasserts (minimum 1).
- CNT_W, default 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_rn, id_rm, id_rd  in  4 each  ID source registers (id_rd is the store-data source).
- id_use_rn, id_use_rm, id_use_rd  in  1 each  matching source register is actually read.
- ex_rd, mem_rd, wb_rd  in  4 each  destination register in EX, MEM, WB.
- ex_rf_e, mem_rf_e, wb_rf_e  in  1 each  register-file write enable in each stage.
- ex_load  in  1  the instruction in EX is a load.
- branch_taken  in  1  ID condition handler resolved a taken branch or BL.
- dmem_busy  in  1  data memory has not completed the current access.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables.
- nop_sel  out  1  1 = force NOP control word into ID/EX.
- ifid_flush  out  1  1 = load NOP into IF/ID on the next edge.
- fwd_a, fwd_b, fwd_c  out  2 each  forwarding selects for rn, rm, rd. 00 = register file, 01 = EX, 10 = MEM, 11 = WB.
- busy  out  1  controller is in HOLD.
- stall_cnt, flush_cnt, wait_cnt  out  CNT_W each  performance counters.

Behaviour:
- States: HOLD, RUN, WAIT. State register is updated on the clk rising edge.
- Reset:
  - State goes to HOLD and the hold counter is loaded with RESET_HOLD-1.
  - All counters clear.
  - Outputs during reset: all enables 0, nop_sel=1, ifid_flush=1, busy=1.
- HOLD:
  - All enables 0, nop_sel=1, ifid_flush=1, busy=1.
  - The hold counter decrements each cycle. When it reaches 0, go to RUN on the next edge.
  - The first RUN cycle fetches PC=0.
- RUN (outputs combinational from inputs and state). Conditions are evaluated in priority order:
  1. dmem_busy=1: all five enables 0, nop_sel=0. Go to WAIT. wait_cnt +1.
  2. Load-use hazard: ex_load & ex_rf_e & (ex_rd == any used ID source) & that source != 4'hF.
     - pc_en=0, ifid_en=0, nop_sel=1. ID/EX, EX/MEM and MEM/WB stay enabled.
     - Exactly one bubble. stall_cnt +1.
     - A simultaneous branch_taken is ignored this cycle and re-evaluated next cycle.
  3. branch_taken=1: all enables 1, ifid_flush=1, nop_sel=0. flush_cnt +1.
  4. Otherwise: all enables 1, nop_sel=0, ifid_flush=0.
- WAIT:
  - All enables 0, nop_sel=0, ifid_flush=0. wait_cnt +1 each cycle.
  - When dmem_busy=0, outputs follow the RUN rules in the same cycle and the state returns to RUN.
  - Load-use and branch conditions are not evaluated while dmem_busy=1.
- Forwarding (purely combinational, valid in every state). Per operand, the youngest matching stage wins:
  - EX wins if ex_rf_e & !ex_load & ex_rd==src.
  - Else MEM wins if mem_rf_e & mem_rd==src.
  - Else WB wins if wb_rf_e & wb_rd==src.
  - Else 00.
  - src==4'hF (PC) or use bit 0 always gives 00.
  - A load in EX never forwards from EX.
- Counters saturate at all-ones with no wrap. They are read-only and cleared only by reset.
- Reset asserted mid-stall or mid-WAIT: the next edge is HOLD with counters cleared. No partial state survives.

Decomposition:
- Shared package pipeline_pkg:
  - state encoding: HOLD=2'd0, RUN=2'd1, WAIT=2'd2.
  - forwarding codes: FWD_RF, FWD_EX, FWD_MEM, FWD_WB.
  - PC_REG=4'hF.
- One sub-module, fwd_select: a combinational per-operand selector, instantiated three times (rn, rm, rd).
- FSM, hazard detect and counters live in the top module.

Test Plan:
- Reset then RESET_HOLD=4 -> busy=1 and pc_en=0 for exactly 4 cycles after reset falls. Cycle 5: pc_en=1, busy=0.
- ex_load=1, ex_rf_e=1, ex_rd=3, id_rn=3, id_use_rn=1 -> one cycle pc_en=0, ifid_en=0, nop_sel=1, stall_cnt=1. The next cycle (load now in MEM, mem_rd=3) gives fwd_a=10.
- ex_rd=mem_rd=wb_rd=5, all rf_e=1, ex_load=0, id_rm=5 used -> fwd_b=01. Drop ex_rf_e -> fwd_b=10. id_rm=4'hF -> fwd_b=00.
- branch_taken=1 with no hazard -> ifid_flush=1, pc_en=1, flush_cnt increments. Same cycle plus load-use on rn=2 -> stall wins, ifid_flush=0, flush_cnt unchanged.
- dmem_busy=1 for 3 cycles -> all enables 0 for 3 cycles, wait_cnt=3. Enables return to 1 in the cycle dmem_busy falls.
- reset pulsed during WAIT -> next cycle busy=1, counters 0. After CNT_W=4 and 20 stalls, stall_cnt holds at 4'hF.
